layer_deserializer: RTL and testbench

// Receive end of the serial neuron-layer stream: collects BIT_SIZE-wide elements arriving one per

---
 rtl/layer_deserializer_if.sv | 27 ++
 rtl/layer_deserializer.sv | 107 ++++++++++
 tb/tb_layer_deserializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_deserializer_if.sv
// Serial element input and parallel frame output of the layer deserializer.
// The slave side is the deserializer; the master side is the feeding stream plus the consumer.
interface layer_deserializer_if #(
  parameter int SIZE     = 3,
  parameter int BIT_SIZE = 1,
  parameter int CNT_W    = 8
);
  logic                          in_valid;
  logic                          in_first;
  logic [BIT_SIZE-1:0]           in_data;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [SIZE-1:0][BIT_SIZE-1:0] out_data;
  logic                          frame_err;
  logic [CNT_W-1:0]              drop_count;

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_err, drop_count
  );

  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_err, drop_count
  );
endinterface

// File: rtl/layer_deserializer.sv
// Assembles SIZE serial elements into a parallel frame; out_valid rises 1 cycle after the last accept.
// One frame assembles while another waits in the output register; a second stalled frame drops in_ready.
module layer_deserializer #(
  parameter int SIZE     = 3,
  parameter int BIT_SIZE = 1,
  parameter int CNT_W    = 8
) (
  input logic                clk,
  input logic                rst_n,
  layer_deserializer_if.slave bus
);
  localparam int               IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT} state_t;

  state_t                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              wr_idx;
  logic [SIZE-1:0][BIT_SIZE-1:0] asm_q;
  logic [SIZE-1:0][BIT_SIZE-1:0] asm_d;
  logic [SIZE-1:0][BIT_SIZE-1:0] out_data_q;
  logic                          out_valid_q;
  logic                          frame_err_q;
  logic [CNT_W-1:0]              drop_count_q;

  logic in_ready;
  logic accept;
  logic out_free;
  logic fire;
  logic store;
  logic last;
  logic drop;

  // in_ready is held low during reset and comes up as soon as reset releases.
  assign in_ready = rst_n && (state_q != WAIT);
  assign accept   = bus.in_valid && in_ready;
  assign out_free = !out_valid_q || bus.out_ready;
  assign fire     = out_valid_q && bus.out_ready;

  always_comb begin
    wr_idx = bus.in_first ? '0 : idx_q;
    store  = accept && (bus.in_first || (state_q == COLLECT));
    drop   = accept && (((state_q == IDLE) && !bus.in_first) ||
                        ((state_q == COLLECT) && bus.in_first));
    last   = store && (wr_idx == LAST_IDX);
    asm_d  = asm_q;
    if (store) begin
      asm_d[wr_idx] = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      asm_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      frame_err_q <= drop;
      if (drop && (drop_count_q != CNT_MAX)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
      if (fire) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        WAIT: begin
          if (out_free) begin
            out_data_q  <= asm_q;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          if (store) begin
            asm_q <= asm_d;
            if (last) begin
              idx_q <= '0;
              // Load straight into the output register when it frees this cycle, else park.
              if (out_free) begin
                out_data_q  <= asm_d;
                out_valid_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              idx_q   <= wr_idx + 1'b1;
              state_q <= COLLECT;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_layer_deserializer.sv
// Scoreboard bench: a frame-level model queues expected frames, a negedge monitor pops on each fire.
module tb_layer_deserializer;
  localparam int SZ = 3;
  localparam int BW = 4;
  localparam int CW = 8;
  localparam int CWB = 3;

  typedef logic [SZ-1:0][BW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  layer_deserializer_if #(.SIZE(SZ), .BIT_SIZE(BW), .CNT_W(CW))  ia ();
  layer_deserializer_if #(.SIZE(1),  .BIT_SIZE(BW), .CNT_W(CWB)) ib ();

  layer_deserializer #(.SIZE(SZ), .BIT_SIZE(BW), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  layer_deserializer #(.SIZE(1), .BIT_SIZE(BW), .CNT_W(CWB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int checks = 0;
  int errors = 0;
  frame_t          exp_q[$];
  logic [BW-1:0]   exp_b[$];
  int              part[$];
  int drops_a = 0, drops_b = 0, err_seen_a = 0, err_seen_b = 0;
  bit rand_rdy = 1'b0;

  function automatic void note(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none at %0t", nm, act, $time);
  endfunction

  // Frame-level view: a frame is the first-marked element plus the next SIZE-1 unmarked ones.
  task automatic model_a(input logic [BW-1:0] d, input bit first);
    frame_t f;
    if (first) begin
      if (part.size() != 0) drops_a++;
      part.delete();
      part.push_back(int'(d));
    end else if (part.size() == 0) begin
      drops_a++;
    end else begin
      part.push_back(int'(d));
    end
    if (part.size() == SZ) begin
      for (int i = 0; i < SZ; i++) f[i] = BW'(part[i]);
      exp_q.push_back(f);
      part.delete();
    end
  endtask

  task automatic model_b(input logic [BW-1:0] d, input bit first);
    if (first) exp_b.push_back(d);
    else drops_b++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.frame_err) err_seen_a++;
      if (ib.frame_err) err_seen_b++;
      if (ia.out_valid && ia.out_ready) begin
        if (exp_q.size() == 0) flag("a_spurious_frame", 64'(ia.out_data));
        else note("a_frame", 64'(ia.out_data), 64'(exp_q.pop_front()));
      end
      if (ib.out_valid && ib.out_ready) begin
        if (exp_b.size() == 0) flag("b_spurious_frame", 64'(ib.out_data));
        else note("b_frame", 64'(ib.out_data), 64'(exp_b.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ia.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle_inputs();
    ia.in_valid = 1'b0;
    ia.in_data  = BW'($urandom);
    ia.in_first = 1'($urandom);
    ib.in_valid = 1'b0;
    ib.in_data  = BW'($urandom);
    ib.in_first = 1'($urandom);
  endtask

  task automatic send_a(input logic [BW-1:0] d, input bit first);
    int n = 0;
    ia.in_valid = 1'b1;
    ia.in_data  = d;
    ia.in_first = first;
    while (!ia.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!ia.in_ready) flag("a_send_timeout", 64'(d));
    else model_a(d, first);
    tick();
    idle_inputs();
  endtask

  task automatic send_b(input logic [BW-1:0] d, input bit first);
    int n = 0;
    ib.in_valid = 1'b1;
    ib.in_data  = d;
    ib.in_first = first;
    while (!ib.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!ib.in_ready) flag("b_send_timeout", 64'(d));
    else model_b(d, first);
    tick();
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #12;
    note("rst_in_ready", 64'(ia.in_ready), 0);
    note("rst_out_valid", 64'(ia.out_valid), 0);
    note("rst_out_data", 64'(ia.out_data), 0);
    note("rst_frame_err", 64'(ia.frame_err), 0);
    note("rst_drop_count", 64'(ia.drop_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 note("rel_in_ready", 64'(ia.in_ready), 1);
    tick();

    // Back-to-back frame with a single-cycle output pulse.
    send_a(4'd5, 1'b1); send_a(4'd9, 1'b0); send_a(4'd2, 1'b0);
    note("t1_valid_lat1", 64'(ia.out_valid), 1);
    note("t1_data", 64'(ia.out_data), 64'h295);
    tick();
    note("t1_pulse_end", 64'(ia.out_valid), 0);

    // Consumer stalled across two frames.
    ia.out_ready = 1'b0;
    send_a(4'd1, 1'b1); send_a(4'd2, 1'b0); send_a(4'd3, 1'b0);
    send_a(4'd4, 1'b1); send_a(4'd5, 1'b0); send_a(4'd6, 1'b0);
    note("t2_in_ready_low", 64'(ia.in_ready), 0);
    tick(); tick();
    note("t2_hold_data", 64'(ia.out_data), 64'h321);
    note("t2_still_blocked", 64'(ia.in_ready), 0);
    ia.out_ready = 1'b1;
    tick();
    note("t2_b_data", 64'(ia.out_data), 64'h654);
    note("t2_b_valid", 64'(ia.out_valid), 1);
    note("t2_in_ready_back", 64'(ia.in_ready), 1);
    tick();
    note("t2_drained", 64'(ia.out_valid), 0);

    // Stray element in IDLE.
    send_a(4'd7, 1'b0);
    note("t3_err_pulse", 64'(ia.frame_err), 1);
    note("t3_no_valid", 64'(ia.out_valid), 0);
    tick();
    note("t3_err_end", 64'(ia.frame_err), 0);
    note("t3_drop_count", 64'(ia.drop_count), 64'(drops_a));

    // New first-marked element aborts a partial frame.
    send_a(4'd1, 1'b1); send_a(4'd2, 1'b0);
    send_a(4'd8, 1'b1);
    note("t4_err_pulse", 64'(ia.frame_err), 1);
    send_a(4'd9, 1'b0); send_a(4'd10, 1'b0);
    note("t4_data", 64'(ia.out_data), 64'hA98);
    tick(); tick();
    note("t4_drop_count", 64'(ia.drop_count), 64'(drops_a));
    note("t4_err_pulses", 64'(err_seen_a), 64'(drops_a));
    note("t4_queue_empty", 64'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a frame.
    send_a(4'd1, 1'b1); send_a(4'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    note("t5_out_data", 64'(ia.out_data), 0);
    note("t5_drop_count", 64'(ia.drop_count), 0);
    note("t5_in_ready", 64'(ia.in_ready), 0);
    note("t5_out_valid", 64'(ia.out_valid), 0);
    part.delete();
    drops_a = 0;
    err_seen_a = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send_a(4'd3, 1'b1); send_a(4'd4, 1'b0); send_a(4'd5, 1'b0);
    note("t5_data", 64'(ia.out_data), 64'h543);
    tick();

    // Randomized stream with random consumer stalls and occasional framing errors.
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bit f;
      f = ((k % SZ) == 0);
      if ($urandom_range(0, 15) == 0) f = ~f;
      send_a(BW'($urandom), f);
    end
    rand_rdy = 1'b0;
    ia.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    note("rnd_queue_empty", 64'(exp_q.size()), 0);
    note("rnd_drop_count", 64'(ia.drop_count), 64'((drops_a > 255) ? 255 : drops_a));
    note("rnd_err_pulses", 64'(err_seen_a), 64'(drops_a));

    // Single-element frames, then drop counter saturation.
    send_b(4'd1, 1'b1);
    note("b_data1", 64'(ib.out_data), 1);
    send_b(4'd2, 1'b1);
    note("b_data2", 64'(ib.out_data), 2);
    send_b(4'd3, 1'b1);
    note("b_data3", 64'(ib.out_data), 3);
    tick();
    note("b_drained", 64'(ib.out_valid), 0);
    for (int k = 0; k < 10; k++) send_b(BW'(k), 1'b0);
    tick(); tick();
    note("b_sat_count", 64'(ib.drop_count), 64'((drops_b > 7) ? 7 : drops_b));
    note("b_err_pulses", 64'(err_seen_b), 64'(drops_b));
    note("b_queue_empty", 64'(exp_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
